// File: rtl/cmp_pkg.sv
// Shared types and helpers for the digit-serial magnitude comparator.
// Optional build macro used by the top: SERIAL_CMP_EARLY_EXIT_EN.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_result_t;

    // Number of DIGIT-wide digits needed to cover WIDTH bits.
    function automatic int ndig(input int width, input int digit);
        return (width + digit - 1) / digit;
    endfunction

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Operand/result handshake bundle for serial_magnitude_comparator.
// master = producer/consumer side, slave = the comparator.
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 6,
    parameter int DIGIT = 2
) ();

    localparam int CW = $clog2(cmp_pkg::ndig(WIDTH, DIGIT) + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             gti;
    logic             lti;
    logic             eqi;
    logic             out_valid;
    logic             out_ready;
    logic             gto;
    logic             lto;
    logic             eqo;
    logic [CW-1:0]    out_digits;

    modport master (
        output in_valid, A, B, gti, lti, eqi, out_ready,
        input  in_ready, out_valid, gto, lto, eqo, out_digits
    );

    modport slave (
        input  in_valid, A, B, gti, lti, eqi, out_ready,
        output in_ready, out_valid, gto, lto, eqo, out_digits
    );

endinterface

// File: rtl/digit_compare.sv
// Combinational unsigned compare of one DIGIT-bit digit.
module digit_compare #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    output logic             gt_o,
    output logic             lt_o
);

    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Digit-serial MSB-first magnitude comparator with 74x85-style cascade
// inputs and valid/ready handshakes on both sides.
// Build option: define SERIAL_CMP_EARLY_EXIT_EN to leave RUN on the edge
// that resolves the first differing digit (result values are unchanged).
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH  = 6,
    parameter int DIGIT  = 2,
    parameter int SIGNED = 0
) (
    input logic                          clk,
    input logic                          rst,
    serial_magnitude_comparator_if.slave bus
);

    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int EXTW = NDIG * DIGIT;
    localparam int CW   = $clog2(NDIG + 1);

    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

    // Flipping the top bit of both two's-complement operands maps the
    // signed order onto the unsigned order, so the datapath stays unsigned.
    localparam logic [EXTW-1:0] BIAS = (SIGNED != 0) ? (EXTW'(1) << (EXTW - 1)) : '0;

    cmp_state_t      state_q, state_d;
    logic [EXTW-1:0] a_q, a_d;
    logic [EXTW-1:0] b_q, b_d;
    logic [EXTW-1:0] a_ext, b_ext;
    cmp_result_t     casc_q, casc_d;
    cmp_result_t     res_q, res_d;
    logic            resolved_q, resolved_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   digits_q, digits_d;
    logic            dig_gt, dig_lt;
    logic            last_dig;

    // Pad operands up to a whole number of digits (zero or sign fill).
    for (genvar i = 0; i < EXTW; i++) begin : g_ext
        if (i < WIDTH) begin : g_op
            assign a_ext[i] = bus.A[i];
            assign b_ext[i] = bus.B[i];
        end else if (SIGNED != 0) begin : g_sx
            assign a_ext[i] = bus.A[WIDTH-1];
            assign b_ext[i] = bus.B[WIDTH-1];
        end else begin : g_zx
            assign a_ext[i] = 1'b0;
            assign b_ext[i] = 1'b0;
        end
    end

    // The current digit always sits at the top of the shift registers.
    digit_compare #(.DIGIT(DIGIT)) u_digit (
        .a_i  (a_q[EXTW-1 -: DIGIT]),
        .b_i  (b_q[EXTW-1 -: DIGIT]),
        .gt_o (dig_gt),
        .lt_o (dig_lt)
    );

    assign last_dig = (cnt_q == LAST_CNT);

    // Next-state: capture in IDLE, shift and resolve in RUN, hold in DONE.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        casc_d     = casc_q;
        res_d      = res_q;
        resolved_d = resolved_q;
        cnt_d      = cnt_q;
        digits_d   = digits_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d        = a_ext ^ BIAS;
                    b_d        = b_ext ^ BIAS;
                    casc_d     = '{gt: bus.gti, lt: bus.lti, eq: bus.eqi};
                    cnt_d      = '0;
                    resolved_d = 1'b0;
                    state_d    = RUN;
                end
            end

            RUN: begin
                a_d   = a_q << DIGIT;
                b_d   = b_q << DIGIT;
                cnt_d = cnt_q + CW'(1);

                // First differing digit decides; later digits are ignored.
                if (!resolved_q) begin
                    if (dig_gt) begin
                        res_d      = '{gt: 1'b1, lt: 1'b0, eq: 1'b0};
                        resolved_d = 1'b1;
                    end else if (dig_lt) begin
                        res_d      = '{gt: 1'b0, lt: 1'b1, eq: 1'b0};
                        resolved_d = 1'b1;
                    end else if (last_dig) begin
                        res_d      = casc_q;
                    end
                end

`ifdef SERIAL_CMP_EARLY_EXIT_EN
                if (last_dig || (!resolved_q && (dig_gt || dig_lt))) begin
`else
                if (last_dig) begin
`endif
                    state_d  = DONE;
                    digits_d = cnt_q + CW'(1);
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            casc_q     <= '0;
            res_q      <= '0;
            resolved_q <= 1'b0;
            cnt_q      <= '0;
            digits_q   <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            casc_q     <= casc_d;
            res_q      <= res_d;
            resolved_q <= resolved_d;
            cnt_q      <= cnt_d;
            digits_q   <= digits_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.gto        = res_q.gt;
    assign bus.lto        = res_q.lt;
    assign bus.eqo        = res_q.eq;
    assign bus.out_digits = digits_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench: u0 = WIDTH 6 / DIGIT 2 unsigned, u1 = WIDTH 7 / DIGIT 3
// signed (padded to 9 bits). Drivers push expected results, per-DUT
// monitors pop and compare whenever out_valid is seen.
module tb_serial_magnitude_comparator;

    typedef struct {
        logic gt;
        logic lt;
        logic eq;
        int   dig;
    } exp_t;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t cur[2];
    bit   seen[2];
    bit   bogus[2];
    int   acc[2];

    serial_magnitude_comparator_if #(.WIDTH(6), .DIGIT(2)) if0 ();
    serial_magnitude_comparator_if #(.WIDTH(7), .DIGIT(3)) if1 ();

    serial_magnitude_comparator #(.WIDTH(6), .DIGIT(2), .SIGNED(0)) u0 (
        .clk (clk), .rst (rst), .bus (if0)
    );
    serial_magnitude_comparator #(.WIDTH(7), .DIGIT(3), .SIGNED(1)) u1 (
        .clk (clk), .rst (rst), .bus (if1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (bound expired)", name);
    endtask

    function automatic exp_t mk(input logic gt, input logic lt, input logic eq, input int dig);
        exp_t e;
        e.gt = gt; e.lt = lt; e.eq = eq; e.dig = dig;
        return e;
    endfunction

    // Behavioural reference: integer compare plus first-differing-digit search.
    function automatic exp_t model(input int id, input logic [6:0] a, input logic [6:0] b,
                                   input logic gi, input logic li, input logic ei);
        exp_t e;
        int   w  = (id == 0) ? 6 : 7;
        int   d  = (id == 0) ? 2 : 3;
        int   nd = 3;
        int   va, vb;
        bit   found = 0;
        va = int'(a) & ((1 << w) - 1);
        vb = int'(b) & ((1 << w) - 1);
        if (id == 1 && va >= (1 << (w - 1))) va -= (1 << w);
        if (id == 1 && vb >= (1 << (w - 1))) vb -= (1 << w);
        e.gt = (va > vb); e.lt = (va < vb); e.eq = 1'b0;
        if (va == vb) begin
            e.gt = gi; e.lt = li; e.eq = ei;
        end
        e.dig = nd;
        if (EE) begin
            for (int k = 0; k < nd; k++) begin
                int sh = (nd - 1 - k) * d;
                int m  = (1 << d) - 1;
                if (!found && (((va >>> sh) & m) != ((vb >>> sh) & m))) begin
                    found = 1;
                    e.dig = k + 1;
                end
            end
        end
        return e;
    endfunction

    task automatic mon(input int id, input logic iv, input logic ir, input logic ov,
                       input logic ordy, input logic gt, input logic lt, input logic eq,
                       input int dig);
        if (rst) begin
            seen[id] = 0;
            return;
        end
        if (iv && ir) acc[id] = cyc + 1;
        if (!ov) return;
        chk($sformatf("u%0d.in_ready_in_done", id), ir, 0);
        if (!seen[id]) begin
            seen[id] = 1;
            bogus[id] = 0;
            if ((id == 0 ? q0.size() : q1.size()) == 0) begin
                bogus[id] = 1;
                fail_now($sformatf("u%0d.unexpected_out_valid", id));
            end else begin
                if (id == 0) cur[id] = q0.pop_front();
                else         cur[id] = q1.pop_front();
                chk($sformatf("u%0d.latency", id), cyc - acc[id], cur[id].dig);
            end
        end
        if (!bogus[id]) begin
            chk($sformatf("u%0d.gto", id), gt, cur[id].gt);
            chk($sformatf("u%0d.lto", id), lt, cur[id].lt);
            chk($sformatf("u%0d.eqo", id), eq, cur[id].eq);
            chk($sformatf("u%0d.out_digits", id), dig, cur[id].dig);
        end
        if (ordy) seen[id] = 0;
    endtask

    always @(negedge clk)
        mon(0, if0.in_valid, if0.in_ready, if0.out_valid, if0.out_ready,
            if0.gto, if0.lto, if0.eqo, int'(if0.out_digits));
    always @(negedge clk)
        mon(1, if1.in_valid, if1.in_ready, if1.out_valid, if1.out_ready,
            if1.gto, if1.lto, if1.eqo, int'(if1.out_digits));

    // Called at posedge+2; waits for in_ready, presents one operation.
    task automatic send(input int id, input logic [6:0] a, input logic [6:0] b,
                        input logic gi, input logic li, input logic ei,
                        input bit push, input exp_t e);
        int n = 0;
        while ((id == 0 ? if0.in_ready : if1.in_ready) !== 1'b1) begin
            @(posedge clk); #2;
            n++;
            if (n > 100) begin
                fail_now($sformatf("u%0d.in_ready_wait", id));
                return;
            end
        end
        if (id == 0) begin
            if0.A = a[5:0]; if0.B = b[5:0];
            if0.gti = gi; if0.lti = li; if0.eqi = ei; if0.in_valid = 1'b1;
        end else begin
            if1.A = a; if1.B = b;
            if1.gti = gi; if1.lti = li; if1.eqi = ei; if1.in_valid = 1'b1;
        end
        if (push) begin
            if (id == 0) q0.push_back(e);
            else         q1.push_back(e);
        end
        @(posedge clk); #2;
        if (id == 0) if0.in_valid = 1'b0;
        else         if1.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || seen[0] || seen[1]) && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 200) fail_now("drain");
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic rnd(input int id, input int count);
        for (int i = 0; i < count; i++) begin
            logic [6:0] a, b;
            logic gi, li, ei;
            a  = 7'($urandom_range(0, 127));
            b  = ($urandom_range(0, 3) == 0) ? a : 7'($urandom_range(0, 127));
            gi = 1'($urandom_range(0, 1));
            li = 1'($urandom_range(0, 1));
            ei = 1'($urandom_range(0, 1));
            send(id, a, b, gi, li, ei, 1, model(id, a, b, gi, li, ei));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        if0.in_valid = 0; if0.A = '0; if0.B = '0; if0.gti = 0; if0.lti = 0; if0.eqi = 0;
        if0.out_ready = 1;
        if1.in_valid = 0; if1.A = '0; if1.B = '0; if1.gti = 0; if1.lti = 0; if1.eqi = 0;
        if1.out_ready = 1;
        rst = 1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst.in_ready", if0.in_ready, 1);
        chk("rst.out_valid", if0.out_valid, 0);
        chk("rst.gto_lto_eqo", {if0.gto, if0.lto, if0.eqo}, 0);
        chk("rst.out_digits", if0.out_digits, 0);
        chk("rst.u1_in_ready", if1.in_ready, 1);
        rst = 0;
        @(posedge clk); #2;

        // u0 directed (6-bit unsigned, 3 digits)
        send(0, 7'd28, 7'd57, 0, 0, 1, 1, mk(0, 1, 0, EE ? 1 : 3));
        send(0, 7'd45, 7'd45, 1, 0, 0, 1, mk(1, 0, 0, 3));
        send(0, 7'd45, 7'd45, 0, 0, 1, 1, mk(0, 0, 1, 3));
        send(0, 7'd63, 7'd62, 0, 0, 0, 1, mk(1, 0, 0, 3));
        send(0, 7'd45, 7'd45, 1, 1, 0, 1, mk(1, 1, 0, 3));
        send(0, 7'd5,  7'd4,  0, 0, 1, 1, mk(1, 0, 0, 3));
        send(0, 7'd0,  7'd63, 1, 0, 0, 1, mk(0, 1, 0, EE ? 1 : 3));
        drain();

        // Backpressure: hold DONE, pulse in_valid, then release.
        if0.out_ready = 0;
        send(0, 7'd28, 7'd57, 0, 0, 1, 1, mk(0, 1, 0, EE ? 1 : 3));
        n = 0;
        while (!if0.out_valid && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        if (!if0.out_valid) fail_now("hold.out_valid_wait");
        repeat (2) @(posedge clk);
        #2;
        if0.A = 6'd7; if0.B = 6'd3; if0.in_valid = 1;
        @(posedge clk); #2;
        if0.in_valid = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("hold.out_valid", if0.out_valid, 1);
        if0.out_ready = 1;
        @(posedge clk); #2;
        chk("release.in_ready", if0.in_ready, 1);
        chk("release.out_valid", if0.out_valid, 0);
        send(0, 7'd63, 7'd62, 0, 0, 0, 1, mk(1, 0, 0, 3));
        drain();

        // Reset mid-RUN: operation abandoned, outputs cleared.
        send(0, 7'd45, 7'd45, 0, 0, 1, 0, mk(0, 0, 0, 0));
        chk("midrun.in_ready", if0.in_ready, 0);
        rst = 1;
        @(posedge clk); #2;
        rst = 0;
        chk("midrun_rst.in_ready", if0.in_ready, 1);
        chk("midrun_rst.out_valid", if0.out_valid, 0);
        chk("midrun_rst.gto_lto_eqo", {if0.gto, if0.lto, if0.eqo}, 0);
        chk("midrun_rst.out_digits", if0.out_digits, 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
            chk("midrun_rst.no_out_valid", if0.out_valid, 0);
        end

        // u1 directed (7-bit signed, padded to 3 digits of 3 bits)
        send(1, 7'd100, 7'd99, 0, 0, 1, 1, mk(1, 0, 0, 3));
        send(1, 7'd127, 7'd1,  0, 0, 1, 1, mk(0, 1, 0, EE ? 1 : 3));
        send(1, 7'd64,  7'd63, 0, 0, 1, 1, mk(0, 1, 0, EE ? 1 : 3));
        send(1, 7'd123, 7'd123, 0, 0, 1, 1, mk(0, 0, 1, 3));
        send(1, 7'd1,   7'd127, 0, 0, 1, 1, mk(1, 0, 0, EE ? 1 : 3));
        drain();

        rnd(0, 1000);
        drain();
        rnd(1, 1000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
- Parametrised, digit-serial successor to the combinational ripple comparator.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, with 74x85-style cascade inputs.
- Uses valid/ready handshakes on input and output so it can sit between pipelined datapath stages.
- Trades latency for area on wide operands; optional signed mode and optional early termination.

Parameters:
- WIDTH, 6, operand width in bits (>=1).
- DIGIT, 2, bits compared per cycle (1..WIDTH).
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operands/cascade inputs presented.
- in_ready  out  1  block can accept; equals (state==IDLE).
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- gti  in  1  cascade greater-than input.
- lti  in  1  cascade less-than input.
- eqi  in  1  cascade equal input.
- out_valid  out  1  result available; equals (state==DONE).
- out_ready  in  1  consumer accepts result.
- gto  out  1  A>B, or gti when A==B.
- lto  out  1  A<B, or lti when A==B.
- eqo  out  1  0 when A!=B, eqi when A==B.
- out_digits  out  $clog2(NDIG+1)  digits examined for this result.

Behaviour:
- Constants:
  - NDIG = ceil(WIDTH/DIGIT).
  - Operands are extended to NDIG*DIGIT bits: zero-extended if SIGNED=0, sign-extended if SIGNED=1.
  - SIGNED=1: the MSB of both extended operands is inverted before comparing. The signed compare then reduces to an unsigned one.
- Reset:
  - state=IDLE; gto=lto=eqo=0; out_digits=0; internal count and shift registers 0.
  - rst wins over every other input on the same edge.
  - rst asserted in RUN or DONE abandons the operation; no out_valid is produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture extended A, B and gti/lti/eqi; clear count; go to RUN.
  - in_valid is ignored in RUN and DONE (no queuing).
- RUN: each edge compares the next digit, starting at the MSB digit.
  - Digit A>B: set gto=1, lto=0, eqo=0; resolved.
  - Digit A<B: set lto=1, gto=0, eqo=0; resolved.
  - Digit equal and last digit: set gto=gti, lto=lti, eqo=eqi.
  - Once resolved, later digits do not change the result.
  - After NDIG RUN edges: go to DONE; out_digits=NDIG.
  - Latency: out_valid rises NDIG edges after the accepting edge (A=28/B=57, WIDTH=6, DIGIT=2 → 3 edges).
- DONE:
  - out_valid=1; gto/lto/eqo/out_digits stable while out_ready=0.
  - On an edge with out_ready=1: go to IDLE. in_ready is 1 in the following cycle.
  - Back-to-back throughput is therefore one result per NDIG+2 cycles.
- Outputs are registered. gto/lto/eqo hold their last value in IDLE and are only meaningful while out_valid=1.
- Conflicting cascade inputs (e.g. gti=lti=1) are passed through unmodified when A==B; no checking is done.
- DIGIT=WIDTH gives NDIG=1, i.e. a single-cycle compare.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN.
- Defined: RUN goes to DONE on the edge that resolves a differing digit. out_digits = index of that digit + 1. Equal operands still take NDIG edges.
- Undefined: RUN always takes exactly NDIG edges; out_digits=NDIG always.
- Result values are identical in both builds; only timing and out_digits differ.

Decomposition:
- Package cmp_pkg:
  - cmp_state_t enum {IDLE, RUN, DONE}.
  - cmp_result_t struct {gt, lt, eq}.
  - Function ndig(WIDTH, DIGIT).
- Sub-module digit_compare: combinational, DIGIT-bit unsigned compare, outputs gt/lt. One instance in RUN datapath.
- Top: FSM, counter, shift registers and handshake.

Test Plan (WIDTH=6, DIGIT=2, SIGNED=0 unless stated):
- A=28, B=57, gti=0, lti=0, eqi=1 → lto=1, gto=0, eqo=0. out_valid after 3 edges, out_digits=3; with EARLY_EXIT_EN, after 1 edge with out_digits=1.
- A=B=45, gti=1, lti=0, eqi=0 → gto=1, lto=0, eqo=0. Same operands with eqi=1, gti=lti=0 → eqo=1. out_digits=3 in both builds.
- A=63, B=62 → gto=1, lto=0, eqo=0; out_digits=3 in both builds (last-digit resolution).
- SIGNED=1: A=6'b111111 (-1), B=1 → lto=1. A=6'b100000 (-32), B=6'b011111 (31) → lto=1. A=B=-5 with eqi=1 → eqo=1.
- Handshakes and reset:
  - Hold out_ready=0 for 5 cycles in DONE: outputs stable, in_ready=0, pulsed in_valid ignored.
  - Raise out_ready: IDLE next cycle, and the next operation is accepted.
  - Assert rst mid-RUN: next cycle state IDLE, all outputs 0, no out_valid.
- WIDTH=7, DIGIT=3 (NDIG=3, padded): A=100, B=99 → gto=1, out_digits=3. Randomised 1000 pairs against a behavioural compare, both builds, SIGNED=0/1.
